// File: rtl/dispense_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// dispense_pkg : state codes, slot codes and coil phases for the sequencer
// Rev 1.0
// ---------------------------------------------------------------------------
package dispense_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE      = 3'd0;
  localparam state_t ST_STEP      = 3'd1;
  localparam state_t ST_WAIT_DROP = 3'd2;
  localparam state_t ST_DONE      = 3'd3;
  localparam state_t ST_FAULT     = 3'd4;

  localparam logic [1:0] SLOT_NONE      = 2'd0;
  localparam logic [1:0] SLOT_MORNING   = 2'd1;
  localparam logic [1:0] SLOT_AFTERNOON = 2'd2;
  localparam logic [1:0] SLOT_EVENING   = 2'd3;

  localparam logic [3:0] COIL_OFF  = 4'b0000;
  localparam logic [3:0] COIL_INIT = 4'b0001;

  // Lowest set request bit wins: morning, then afternoon, then evening.
  function automatic logic [1:0] pick_slot(input logic [2:0] req);
    if (req[0])      return SLOT_MORNING;
    else if (req[1]) return SLOT_AFTERNOON;
    else if (req[2]) return SLOT_EVENING;
    else             return SLOT_NONE;
  endfunction

  function automatic logic [2:0] slot_mask(input logic [1:0] s);
    case (s)
      SLOT_MORNING:   return 3'b001;
      SLOT_AFTERNOON: return 3'b010;
      SLOT_EVENING:   return 3'b100;
      default:        return 3'b000;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/dispense_sequencer_pulse_sync.sv
`default_nettype none
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// pulse_sync : 2-flop synchronizer plus registered edge detect
// Rev 1.0
// ---------------------------------------------------------------------------
module pulse_sync #(
  parameter bit RISING = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic pulse
);

  // Resetting to the inactive level avoids a spurious edge after reset.
  localparam logic IDLE_LVL = !RISING;

  logic [1:0] sync_q, sync_d;
  logic       prev_q, prev_d;
  logic       pulse_q, pulse_d;

  always_comb begin
    sync_d  = {sync_q[0], din};
    prev_d  = sync_q[1];
    pulse_d = RISING ? (sync_q[1] & ~prev_q) : (~sync_q[1] & prev_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= {2{IDLE_LVL}};
      prev_q  <= IDLE_LVL;
      pulse_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      prev_q  <= prev_d;
      pulse_q <= pulse_d;
    end
  end

  assign pulse = pulse_q;

endmodule
`default_nettype wire

// File: rtl/dispense_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// dispense_sequencer : queues dose requests, steps the carousel, awaits drop.
// Optional DISPENSE_MANUAL_EN adds active-low manual request buttons.
// Rev 1.0
// ---------------------------------------------------------------------------
module dispense_sequencer
  import dispense_pkg::*;
#(
  parameter int unsigned STEP_DIV       = 500000,
  parameter int unsigned STEPS_PER_DOSE = 64,
  parameter int unsigned DROP_TIMEOUT   = 100000000,
  parameter int unsigned MAX_RETRY      = 2
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       morningP,
  input  logic       afternoonP,
  input  logic       eveningP,
  input  logic       pillSensor,
  input  logic       clearFault,
`ifdef DISPENSE_MANUAL_EN
  input  logic [2:0] manualBtn,
`endif
  output logic [3:0] coil,
  output logic [1:0] slot,
  output logic [2:0] pending,
  output logic       busy,
  output logic       donePulse,
  output logic       fault
);

  localparam int DIV_W = (STEP_DIV > 1)       ? $clog2(STEP_DIV)       : 1;
  localparam int PH_W  = (STEPS_PER_DOSE > 1) ? $clog2(STEPS_PER_DOSE) : 1;
  localparam int TMO_W = (DROP_TIMEOUT > 1)   ? $clog2(DROP_TIMEOUT)   : 1;
  localparam int RTY_W = (MAX_RETRY > 0)      ? $clog2(MAX_RETRY + 1)  : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(STEP_DIV - 1);
  localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(STEPS_PER_DOSE - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(DROP_TIMEOUT - 1);
  localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRY);

  state_t           state_q, state_d;
  logic [3:0]       coil_q, coil_d;
  logic [1:0]       slot_q, slot_d;
  logic [2:0]       pending_q, pending_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [PH_W-1:0]  phase_q, phase_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [RTY_W-1:0] retry_q, retry_d;
  logic             drop_seen_q, drop_seen_d;
  logic             enter_step;
  logic             drop_pulse;
  logic [2:0]       req;

  pulse_sync #(.RISING(1'b1)) u_drop_sync (
    .clk   (CLOCK_50),
    .rst_n (reset),
    .din   (pillSensor),
    .pulse (drop_pulse)
  );

`ifdef DISPENSE_MANUAL_EN
  logic [2:0] manual_req;

  for (genvar i = 0; i < 3; i++) begin : g_manual
    pulse_sync #(.RISING(1'b0)) u_btn_sync (
      .clk   (CLOCK_50),
      .rst_n (reset),
      .din   (manualBtn[i]),
      .pulse (manual_req[i])
    );
  end

  assign req = {eveningP, afternoonP, morningP} | manual_req;
`else
  assign req = {eveningP, afternoonP, morningP};
`endif

  always_comb begin
    state_d     = state_q;
    coil_d      = coil_q;
    slot_d      = slot_q;
    pending_d   = pending_q;
    div_d       = div_q;
    phase_d     = phase_q;
    tmo_d       = tmo_q;
    retry_d     = retry_q;
    drop_seen_d = drop_seen_q;
    enter_step  = 1'b0;

    if (drop_pulse && (state_q == ST_STEP || state_q == ST_WAIT_DROP))
      drop_seen_d = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (|pending_q) begin
          slot_d     = pick_slot(pending_q);
          pending_d  = pending_q & ~slot_mask(slot_d);
          retry_d    = '0;
          enter_step = 1'b1;
          state_d    = ST_STEP;
        end
      end
      ST_STEP: begin
        if (div_q == DIV_LAST) begin
          div_d = '0;
          if (phase_q == PH_LAST) begin
            coil_d  = COIL_OFF;
            tmo_d   = '0;
            state_d = ST_WAIT_DROP;
          end else begin
            phase_d = phase_q + PH_W'(1);
            coil_d  = {coil_q[2:0], coil_q[3]};
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      ST_WAIT_DROP: begin
        if (drop_seen_q) begin
          slot_d  = SLOT_NONE;
          state_d = ST_DONE;
        end else if (tmo_q == TMO_LAST) begin
          if (retry_q < RTY_MAX) begin
            retry_d    = retry_q + RTY_W'(1);
            enter_step = 1'b1;
            state_d    = ST_STEP;
          end else begin
            state_d = ST_FAULT;
          end
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      ST_FAULT: begin
        if (clearFault) begin
          slot_d  = SLOT_NONE;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Every attempt restarts the phase sequence and forgets earlier drops.
    if (enter_step) begin
      coil_d      = COIL_INIT;
      div_d       = '0;
      phase_d     = '0;
      drop_seen_d = 1'b0;
    end

    pending_d = pending_d | req;
  end

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      coil_q      <= COIL_OFF;
      slot_q      <= SLOT_NONE;
      pending_q   <= '0;
      div_q       <= '0;
      phase_q     <= '0;
      tmo_q       <= '0;
      retry_q     <= '0;
      drop_seen_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      coil_q      <= coil_d;
      slot_q      <= slot_d;
      pending_q   <= pending_d;
      div_q       <= div_d;
      phase_q     <= phase_d;
      tmo_q       <= tmo_d;
      retry_q     <= retry_d;
      drop_seen_q <= drop_seen_d;
    end
  end

  assign coil      = coil_q;
  assign slot      = slot_q;
  assign pending   = pending_q;
  assign busy      = (state_q == ST_STEP) || (state_q == ST_WAIT_DROP);
  assign donePulse = (state_q == ST_DONE);
  assign fault     = (state_q == ST_FAULT);

endmodule
`default_nettype wire
